// File: rtl/ita_package.sv
// ita_package: shared types, sizes and step loop tables for the ITA tile sequencer
package ita_package;
  localparam int unsigned FifoDepth = 14;
  localparam int unsigned N_REQUANT_CONSTS = 8;
  localparam int unsigned TileW = 8;
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [TileW-1:0] tile_t;
  typedef logic [$clog2(FifoDepth+1)-1:0] ongoing_t;
  typedef enum logic [1:0] {Attention, Feedforward, Linear} layer_e;
  typedef enum logic [3:0] {
    StepIdle, StepQ, StepK, StepV, StepQK, StepAV, StepOW, StepF1, StepF2, StepMatMul
  } step_e;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} seq_state_e;
  typedef struct packed {
    logic   start;
    layer_e layer;
    tile_t  tile_s;
    tile_t  tile_e;
    tile_t  tile_p;
    tile_t  tile_f;
  } ctrl_t;
  typedef enum logic [1:0] {DimS, DimE, DimP, DimF} dim_e;
  typedef struct packed {
    dim_e outer;
    dim_e mid;
    dim_e inner;
  } loop_sel_t;
  function automatic loop_sel_t step_loops(input step_e st);
    case (st)
      StepQ, StepK, StepV: return '{DimS, DimP, DimE};
      StepQK:              return '{DimS, DimS, DimP};
      StepAV:              return '{DimS, DimP, DimS};
      StepOW:              return '{DimS, DimE, DimP};
      StepF2:              return '{DimS, DimE, DimF};
      default:             return '{DimS, DimF, DimE};
    endcase
  endfunction
endpackage

// File: rtl/ita_tile_counter.sv
// ita_tile_counter: outer/mid/inner nested tile counter, a zero count behaves as one
module ita_tile_counter
  import ita_package::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  advance,
  input  tile_t cnt_outer,
  input  tile_t cnt_mid,
  input  tile_t cnt_inner,
  output tile_t outer,
  output tile_t mid,
  output tile_t inner,
  output logic  first_inner,
  output logic  last_inner,
  output logic  last
);
  tile_t max_o, max_m, max_i;
  logic last_mid, last_outer;
  always_comb begin
    max_o = (cnt_outer == '0) ? '0 : cnt_outer - 1'b1;
    max_m = (cnt_mid == '0) ? '0 : cnt_mid - 1'b1;
    max_i = (cnt_inner == '0) ? '0 : cnt_inner - 1'b1;
    first_inner = inner == '0;
    last_inner = inner == max_i;
    last_mid = mid == max_m;
    last_outer = outer == max_o;
    last = last_inner && last_mid && last_outer;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outer <= '0;
      mid <= '0;
      inner <= '0;
    end else if (clear) begin
      outer <= '0;
      mid <= '0;
      inner <= '0;
    end else if (advance) begin
      inner <= last_inner ? '0 : inner + 1'b1;
      if (last_inner) mid <= last_mid ? '0 : mid + 1'b1;
      if (last_inner && last_mid) outer <= last_outer ? '0 : outer + 1'b1;
    end
  end
endmodule

// File: rtl/ita_tile_sequencer.sv
// ita_tile_sequencer: walks the steps of a layer, issuing tiles with bounded outstanding work
module ita_tile_sequencer
  import ita_package::*;
#(
  parameter int unsigned MaxOutstanding = FifoDepth
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  ctrl_t                                 ctrl_i,
  output logic                                  busy_o,
  output step_e                                 step_o,
  output logic [idx_width(N_REQUANT_CONSTS)-1:0] requant_idx_o,
  output logic                                  tile_valid_o,
  input  logic                                  tile_ready_i,
  output tile_t                                 tile_outer_o,
  output tile_t                                 tile_mid_o,
  output tile_t                                 tile_inner_o,
  output logic                                  first_inner_o,
  output logic                                  last_inner_o,
  input  logic                                  tile_done_i,
  output logic                                  done_o,
  output logic                                  err_o
);
  localparam int unsigned RqW = idx_width(N_REQUANT_CONSTS);
  seq_state_e state_q, state_d;
  step_e step_d, first_step;
  tile_t [3:0] dims_q;
  ongoing_t out_q;
  loop_sel_t sel;
  tile_t cnt_o, cnt_m, cnt_i;
  logic hs, accept, drained, last_step, last_tile, first_in, last_in, dec;
  always_comb begin
    sel = step_loops(step_o);
    cnt_o = dims_q[sel.outer];
    cnt_m = dims_q[sel.mid];
    cnt_i = dims_q[sel.inner];
    busy_o = state_q != IDLE;
    tile_valid_o = state_q == ISSUE && out_q < ongoing_t'(MaxOutstanding);
    first_inner_o = state_q == ISSUE && first_in;
    last_inner_o = state_q == ISSUE && last_in;
    requant_idx_o = (step_o == StepIdle) ? '0 :
                    (step_o == StepMatMul) ? RqW'(6) : RqW'(step_o - 1'b1);
    hs = tile_valid_o && tile_ready_i;
    accept = state_q == IDLE && ctrl_i.start;
    drained = state_q == DRAIN && out_q == '0;
    dec = tile_done_i && out_q != '0;
    last_step = step_o inside {StepOW, StepF2, StepMatMul};
    first_step = (ctrl_i.layer == Attention) ? StepQ :
                 (ctrl_i.layer == Feedforward) ? StepF1 : StepMatMul;
    state_d = state_q;
    step_d = step_o;
    if (accept) begin
      state_d = ISSUE;
      step_d = first_step;
    end else if (hs && last_tile) begin
      state_d = DRAIN;
    end else if (drained) begin
      state_d = last_step ? IDLE : ISSUE;
      step_d = last_step ? StepIdle : step_e'(step_o + 1'b1);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      step_o <= StepIdle;
    end else begin
      state_q <= state_d;
      step_o <= step_d;
    end
  end
  // a completion with nothing outstanding is dropped but flagged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
      err_o <= 1'b0;
      done_o <= 1'b0;
      dims_q <= '0;
    end else begin
      out_q <= out_q + ongoing_t'(hs) - ongoing_t'(dec);
      err_o <= accept ? 1'b0 : (err_o | (tile_done_i && out_q == '0));
      done_o <= drained && last_step;
      if (accept) dims_q <= {ctrl_i.tile_f, ctrl_i.tile_p, ctrl_i.tile_e, ctrl_i.tile_s};
    end
  end
  ita_tile_counter u_cnt (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .clear      (accept || drained),
    .advance    (hs),
    .cnt_outer  (cnt_o),
    .cnt_mid    (cnt_m),
    .cnt_inner  (cnt_i),
    .outer      (tile_outer_o),
    .mid        (tile_mid_o),
    .inner      (tile_inner_o),
    .first_inner(first_in),
    .last_inner (last_in),
    .last       (last_tile)
  );
endmodule

// File: tb/tb_ita_tile_sequencer.sv
// tb_ita_tile_sequencer: directed checks of step order, tile order, throttling, errors and reset
module tb_ita_tile_sequencer;
  import ita_package::*;
  logic clk = 1'b0;
  logic rst_ni;
  ctrl_t ctrl;
  logic busy, valid, ready, fi, li, tdone, done, err;
  step_e step;
  logic [idx_width(N_REQUANT_CONSTS)-1:0] rq;
  tile_t to, tm, ti;
  logic auto_done, man_done;
  logic [1:0] pipe = '0;
  int checks = 0, failures = 0, n_done = 0;
  typedef struct {int st, o, m, i, f, l, rq;} ent_t;
  ent_t log_q[$];

  always #5 clk = ~clk;

  ita_tile_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni), .ctrl_i(ctrl), .busy_o(busy), .step_o(step),
    .requant_idx_o(rq), .tile_valid_o(valid), .tile_ready_i(ready),
    .tile_outer_o(to), .tile_mid_o(tm), .tile_inner_o(ti),
    .first_inner_o(fi), .last_inner_o(li), .tile_done_i(tdone),
    .done_o(done), .err_o(err)
  );

  // completion model: each accepted tile finishes two cycles later
  always @(posedge clk) begin
    pipe <= {pipe[0], valid && ready};
    if (valid && ready)
      log_q.push_back('{int'(step), int'(to), int'(tm), int'(ti), int'(fi), int'(li), int'(rq)});
    if (done) n_done++;
  end
  assign tdone = (auto_done && pipe[1]) || man_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic start_job(input int layer, input int s, input int e, input int p, input int f);
    @(negedge clk);
    ctrl.layer = layer_e'(layer[1:0]);
    ctrl.tile_s = tile_t'(s);
    ctrl.tile_e = tile_t'(e);
    ctrl.tile_p = tile_t'(p);
    ctrl.tile_f = tile_t'(f);
    ctrl.start = 1'b1;
    @(posedge clk);
    #1 ctrl.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {busy, valid, fi, li, done, step, rq}, 0);
    check({tag, "_idx"}, {to, tm, ti}, 0);
  endtask

  initial begin
    int p0, d0, n, bad, c1, c2, j;
    logic sv;
    logic [27:0] saved;
    rst_ni = 1'b0;
    ctrl = '0;
    ready = 1'b1;
    auto_done = 1'b0;
    man_done = 1'b0;
    #1 check_idle("t0_rst");
    check("t0_err", err, 0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check_idle("t0_post");

    // attention, all tiles 1
    auto_done = 1'b1;
    p0 = log_q.size();
    d0 = n_done;
    start_job(0, 1, 1, 1, 1);
    check("t1_valid", valid, 1);
    check("t1_step", step, StepQ);
    check("t1_busy", busy, 1);
    wait_done("t1_done", 300);
    check("t1_issues", log_q.size() - p0, 6);
    bad = 0;
    for (int k = 0; k < 6 && p0 + k < log_q.size(); k++)
      if (log_q[p0+k].st != k + 1 || log_q[p0+k].rq != k || log_q[p0+k].f != 1 || log_q[p0+k].l != 1)
        bad++;
    check("t1_seq", bad, 0);
    repeat (3) @(negedge clk);
    check("t1_done_cnt", n_done - d0, 1);
    check_idle("t1_idle");

    // feedforward s=2 e=3 f=2
    p0 = log_q.size();
    d0 = n_done;
    start_job(1, 2, 3, 1, 2);
    check("t2_step", step, StepF1);
    wait_done("t2_done", 600);
    check("t2_issues", log_q.size() - p0, 24);
    bad = 0;
    c1 = 0;
    c2 = 0;
    for (int k = 0; k < 24 && p0 + k < log_q.size(); k++) begin
      if (k < 12) begin
        if (log_q[p0+k].st != StepF1 || log_q[p0+k].rq != 6 || log_q[p0+k].o != k / 6 ||
            log_q[p0+k].m != (k / 3) % 2 || log_q[p0+k].i != k % 3 ||
            log_q[p0+k].f != int'(k % 3 == 0) || log_q[p0+k].l != int'(k % 3 == 2)) bad++;
        c1 += log_q[p0+k].l;
      end else begin
        j = k - 12;
        if (log_q[p0+k].st != StepF2 || log_q[p0+k].rq != 7 || log_q[p0+k].o != j / 6 ||
            log_q[p0+k].m != (j / 2) % 3 || log_q[p0+k].i != j % 2 ||
            log_q[p0+k].f != int'(j % 2 == 0) || log_q[p0+k].l != int'(j % 2 == 1)) bad++;
        c2 += log_q[p0+k].l;
      end
    end
    check("t2_order", bad, 0);
    check("t2_f1_last", c1, 4);
    check("t2_f2_last", c2, 6);
    repeat (3) @(negedge clk);
    check("t2_done_cnt", n_done - d0, 1);

    // linear e=20 with completions withheld
    auto_done = 1'b0;
    p0 = log_q.size();
    d0 = n_done;
    start_job(2, 1, 20, 1, 1);
    check("t3_step", step, StepMatMul);
    check("t3_rq", rq, 6);
    repeat (40) @(negedge clk);
    check("t3_cap", log_q.size() - p0, 14);
    check("t3_valid_low", valid, 0);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (5) @(negedge clk);
    check("t3_one_more", log_q.size() - p0, 15);
    check("t3_valid_low2", valid, 0);
    repeat (19) begin
      @(negedge clk);
      man_done = 1'b1;
    end
    @(negedge clk);
    man_done = 1'b0;
    wait_done("t3_done", 100);
    check("t3_issues", log_q.size() - p0, 20);
    check("t3_err", err, 0);
    check("t3_done_cnt", n_done - d0, 1);

    // attention s=e=p=2 with random ready
    auto_done = 1'b1;
    ready = 1'b0;
    p0 = log_q.size();
    d0 = n_done;
    start_job(0, 2, 2, 2, 1);
    n = 0;
    bad = 0;
    sv = 1'b0;
    saved = '0;
    while (!done && n < 3000) begin
      @(negedge clk);
      if (sv && (!valid || {to, tm, ti, step} !== saved)) bad++;
      ready = 1'($urandom_range(0, 1));
      sv = valid && !ready;
      saved = {to, tm, ti, step};
      n++;
    end
    ready = 1'b1;
    check("t4_done", done, 1);
    check("t4_stable", bad, 0);
    check("t4_issues", log_q.size() - p0, 48);
    bad = 0;
    c1 = 0;
    for (int k = p0; k < log_q.size(); k++)
      if (log_q[k].st == StepQ) begin
        if (log_q[k].o != c1 / 4 || log_q[k].m != (c1 / 2) % 2 || log_q[k].i != c1 % 2) bad++;
        c1++;
      end
    check("t4_q_count", c1, 8);
    check("t4_q_order", bad, 0);
    repeat (3) @(negedge clk);
    check("t4_done_cnt", n_done - d0, 1);

    // stray completion in idle, then zero tile counts and an ignored second start
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    check("t5_err_set", err, 1);
    repeat (3) @(negedge clk);
    check("t5_err_sticky", err, 1);
    ready = 1'b0;
    p0 = log_q.size();
    d0 = n_done;
    start_job(0, 0, 0, 0, 0);
    check("t5_err_clr", err, 0);
    check("t5_step", step, StepQ);
    @(negedge clk);
    ctrl.layer = Linear;
    ctrl.start = 1'b1;
    @(negedge clk);
    ctrl.start = 1'b0;
    check("t5_step_kept", step, StepQ);
    check("t5_busy", busy, 1);
    ready = 1'b1;
    wait_done("t5_done", 300);
    check("t5_issues", log_q.size() - p0, 6);
    c1 = 0;
    for (int k = p0; k < log_q.size(); k++) if (log_q[k].st == StepMatMul) c1++;
    check("t5_no_matmul", c1, 0);
    repeat (10) @(negedge clk);
    check("t5_done_cnt", n_done - d0, 1);
    check("t5_idle", busy, 0);

    // reset during QK drain with five outstanding
    p0 = log_q.size();
    start_job(0, 1, 1, 5, 1);
    n = 0;
    while (step !== StepQK && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_qk", step, StepQK);
    auto_done = 1'b0;
    repeat (8) @(negedge clk);
    c1 = 0;
    for (int k = p0; k < log_q.size(); k++) if (log_q[k].st == StepQK) c1++;
    check("t6_qk_issued", c1, 5);
    check("t6_qk_drain", {busy, valid}, 2'b10);
    #2 rst_ni = 1'b0;
    #1 check_idle("t6_rst");
    check("t6_err", err, 0);
    d0 = n_done;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_no_done", n_done - d0, 0);
    check("t6_idle", busy, 0);
    auto_done = 1'b1;
    p0 = log_q.size();
    start_job(0, 1, 1, 1, 1);
    check("t6_restart_step", step, StepQ);
    wait_done("t6_done", 300);
    check("t6_issues", log_q.size() - p0, 6);
    check("t6_err_end", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ita_tile_sequencer.md
ITA_TILE_SEQUENCER -- requirements
Module: ita_tile_sequencer

Interface
REQ-001 SHALL have parameter MaxOutstanding, default FifoDepth (14), meaning maximum issued-but-uncompleted tiles.
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ctrl_i  input  ctrl_t  layer config; start, layer, tile_s/e/p/f used.
REQ-005 SHALL have port busy_o  output  1  job in progress.
REQ-006 SHALL have port step_o  output  step_e  current step.
REQ-007 SHALL have port requant_idx_o  output  idx_width(N_REQUANT_CONSTS)  index into eps_mult/right_shift/add arrays.
REQ-008 SHALL have port tile_valid_o / tile_ready_i  output/input  1/1  tile-issue handshake.
REQ-009 SHALL have ports tile_outer_o, tile_mid_o, tile_inner_o  output  tile_t each  indices of issued tile.
REQ-010 SHALL have ports first_inner_o, last_inner_o  output  1 each  issued tile opens/closes accumulation.
REQ-011 SHALL have port tile_done_i  input  1  one-cycle pulse per completed tile.
REQ-012 SHALL have ports done_o (1-cycle pulse) and err_o (sticky)  output  1 each.

Function
REQ-013 SHALL use states IDLE, ISSUE, DRAIN; ctrl_i fields latched on accepted start.
REQ-014 SHALL accept start only in IDLE when ctrl_i.start=1; start while busy ignored.
REQ-015 SHALL run steps: Attention Q,K,V,QK,AV,OW; Feedforward F1,F2; Linear MatMul.
REQ-016 SHALL use loop counts (outer,mid,inner): Q/K/V (s,p,e); QK (s,s,p); AV (s,p,s); OW (s,e,p); F1 and MatMul (s,f,e); F2 (s,e,f); tile count 0 treated as 1.
REQ-017 SHALL iterate inner fastest, then mid, then outer, advancing only on tile_valid_o&&tile_ready_i.
REQ-018 SHALL drive first_inner_o when inner index=0, last_inner_o when inner index=count-1.
REQ-019 SHALL drive requant_idx_o = step_o-1 for Q..F2 and 6 for MatMul; 0 in IDLE.
REQ-020 SHALL keep outstanding counter (ongoing_t): +1 on handshake, -1 on tile_done_i, unchanged when both same cycle.
REQ-021 SHALL deassert tile_valid_o when outstanding = MaxOutstanding and in DRAIN/IDLE.
REQ-022 SHALL enter DRAIN after last tile of a step handshakes; leave when outstanding reaches 0.
REQ-023 SHALL, on drain completion, present next step with tile_valid_o=1 and indices 0 on the following cycle.
REQ-024 SHALL, on drain completion of final step, pulse done_o for one cycle and return to IDLE the same edge.
REQ-025 SHALL assert tile_valid_o the cycle after accepted start with step_o = first step.
REQ-026 SHALL hold tile_valid_o and all index outputs stable while tile_ready_i=0.
REQ-027 SHALL ignore tile_done_i with outstanding=0, setting err_o; err_o cleared on next accepted start.
REQ-028 SHALL treat layer values other than 0..2 as Linear.

Reset
REQ-029 SHALL on rst_ni=0 force IDLE, step_o=Idle, all indices/counters 0, all 1-bit outputs 0, asynchronously.
REQ-030 SHALL abandon any job on reset mid-operation; no done_o issued afterward.

Structure
REQ-031 SHALL keep MaxOutstanding default, seq_state_e enum, and step loop-count table types in ita_package.
REQ-032 SHALL instantiate one sub-module ita_tile_counter (3-level nested counter with first/last flags).

Verification
REQ-033 Attention, all tiles 1, ready=1, done 2 cycles after each issue -> six steps Q..OW, 6 issues, one done_o, requant_idx 0..5.
REQ-034 Feedforward tile_s=2,e=3,f=2, ready=1 -> F1 issues 12 tiles, last_inner every 3rd; F2 12 tiles, last_inner every 2nd; done_o once.
REQ-035 Linear tile_s=1,f=1,e=20, tile_done_i withheld -> exactly 14 issues, then valid low; one done pulse -> one more issue.
REQ-036 ready toggled randomly on Q step -> indices stable while ready=0, no tile skipped or repeated.
REQ-037 tile_done_i pulse in IDLE -> err_o=1, sticky until next start; second start during busy ignored.
REQ-038 rst_ni low mid-QK with outstanding=5 -> all outputs 0 immediately, no done_o; new start runs cleanly from Q.
